// File: rtl/pc_fetch_ctrl_if.sv
// Bus bundle between the top level and the program-counter / fetch-sequencing stage.
//
// Run handshake: the master raises start for at least one cycle while the stage
// is idle or done. The stage then enters RUN on the next edge. When a halt
// instruction retires, the stage raises ack at that same edge and keeps it high
// until the next start or reset. start seen while running is ignored.
interface pc_fetch_ctrl_if #(
  parameter int PCW  = 10,
  parameter int LUTW = 4,
  parameter int CNTW = 16
);
  logic            start;
  logic            stall;
  logic            halt;
  logic            branch;
  logic            jump;
  logic [LUTW-1:0] lut_idx;
  logic            lut_we;
  logic [LUTW-1:0] lut_waddr;
  logic [PCW-1:0]  lut_wdata;
  logic [PCW-1:0]  pc;
  logic            running;
  logic            ack;
  logic [CNTW-1:0] cycle_cnt;
  logic [1:0]      dbg_state;

  modport master (
    output start, stall, halt, branch, jump, lut_idx, lut_we, lut_waddr, lut_wdata,
    input  pc, running, ack, cycle_cnt, dbg_state
  );

  modport slave (
    input  start, stall, halt, branch, jump, lut_idx, lut_we, lut_waddr, lut_wdata,
    output pc, running, ack, cycle_cnt, dbg_state
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE run control, a branch-target
// lookup table, zero-bubble taken branches and a saturating run-cycle counter.
module pc_fetch_ctrl #(
  parameter int PCW  = 10,
  parameter int LUTW = 4,
  parameter int CNTW = 16
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic            ack_q, ack_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PCW-1:0]  lut [2**LUTW];
  logic [PCW-1:0]  target;

  // Branch target is read from the stored array, so a same-cycle write is not seen.
  assign target = lut[bus.lut_idx];

  // Register state, PC, ack and cycle counter; reset returns to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Target table: writes accepted in every state, reset clears it and wins over writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**LUTW; i++) lut[i] <= '0;
    end else if (bus.lut_we) begin
      lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  // Next state: run control and one PC update per edge in priority stall > halt > branch > step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Every RUN edge counts, stalls and the halt edge included; saturate at all-ones.
        if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
        if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.halt) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
        end else if (bus.branch && bus.jump) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PCW'(1);
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        ack_d   = 1'b0;
      end
    endcase
  end

  // Outputs: running and the debug state view are decoded from the current state.
  always_comb begin
    bus.running   = (state_q == S_RUN);
    bus.dbg_state = state_q;
  end

  assign bus.pc        = pc_q;
  assign bus.ack       = ack_q;
  assign bus.cycle_cnt = cnt_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed walk through the run/branch/stall/halt/reset
// scenarios followed by random traffic, all compared against a behavioural model.
// A second instance with a 4-bit counter shares the stimulus to reach saturation.
module tb_pc_fetch_ctrl;
  localparam int PCW    = 10;
  localparam int LUTW   = 4;
  localparam int CNTW   = 16;
  localparam int CNTW_S = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.PCW(PCW), .LUTW(LUTW), .CNTW(CNTW))   bus ();
  pc_fetch_ctrl_if #(.PCW(PCW), .LUTW(LUTW), .CNTW(CNTW_S)) bus_s ();

  pc_fetch_ctrl #(.PCW(PCW), .LUTW(LUTW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pc_fetch_ctrl #(.PCW(PCW), .LUTW(LUTW), .CNTW(CNTW_S)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  assign bus_s.start     = bus.start;
  assign bus_s.stall     = bus.stall;
  assign bus_s.halt      = bus.halt;
  assign bus_s.branch    = bus.branch;
  assign bus_s.jump      = bus.jump;
  assign bus_s.lut_idx   = bus.lut_idx;
  assign bus_s.lut_we    = bus.lut_we;
  assign bus_s.lut_waddr = bus.lut_waddr;
  assign bus_s.lut_wdata = bus.lut_wdata;

  // ---------------- reference model ----------------
  int m_mode;
  int m_pc;
  int m_ack;
  int m_cnt;      // unbounded count of RUN edges; clamped per counter width when compared
  int m_lut [16];

  int total = 0;
  int bad   = 0;

  function automatic int clamp(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge();
    int tgt;
    if (reset) begin
      m_mode = M_IDLE;
      m_pc   = 0;
      m_ack  = 0;
      m_cnt  = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
      return;
    end
    tgt = m_lut[int'(bus.lut_idx)];
    if (m_mode == M_IDLE) begin
      if (bus.start) begin m_mode = M_RUN; m_pc = 0; m_cnt = 0; end
    end else if (m_mode == M_RUN) begin
      m_cnt = m_cnt + 1;
      if (!bus.stall) begin
        if (bus.halt) begin m_mode = M_DONE; m_ack = 1; end
        else if (bus.branch && bus.jump) m_pc = tgt;
        else m_pc = (m_pc + 1) % (1 << PCW);
      end
    end else begin
      if (bus.start) begin m_mode = M_RUN; m_pc = 0; m_cnt = 0; m_ack = 0; end
    end
    if (bus.lut_we) m_lut[int'(bus.lut_waddr)] = int'(bus.lut_wdata);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc",       32'(bus.pc),          32'(m_pc));
    check("ack",      32'(bus.ack),         32'(m_ack));
    check("running",  32'(bus.running),     32'(m_mode == M_RUN));
    check("cnt",      32'(bus.cycle_cnt),   32'(clamp(m_cnt, CNTW)));
    check("pc_s",     32'(bus_s.pc),        32'(m_pc));
    check("cnt_s",    32'(bus_s.cycle_cnt), 32'(clamp(m_cnt, CNTW_S)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.halt      = 1'b0;
    bus.branch    = 1'b0;
    bus.jump      = 1'b0;
    bus.lut_idx   = '0;
    bus.lut_we    = 1'b0;
    bus.lut_waddr = '0;
    bus.lut_wdata = '0;
  endtask

  // One clock: inputs are already set; model follows the edge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic lut_write(input int a, input int d);
    bus.lut_we    = 1'b1;
    bus.lut_waddr = LUTW'(a);
    bus.lut_wdata = PCW'(d);
    tick();
    bus.lut_we    = 1'b0;
  endtask

  task automatic take_branch(input int idx);
    bus.branch  = 1'b1;
    bus.jump    = 1'b1;
    bus.lut_idx = LUTW'(idx);
    tick();
    bus.branch  = 1'b0;
    bus.jump    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  int snap_cnt;

  initial begin
    idle_inputs();
    for (int i = 0; i < 16; i++) m_lut[i] = 0;
    m_mode = M_IDLE; m_pc = 0; m_ack = 0; m_cnt = 0;

    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_pc",      32'(bus.pc),        32'h0);
    check("rst_ack",     32'(bus.ack),       32'h0);
    check("rst_running", 32'(bus.running),   32'h0);
    check("rst_cnt",     32'(bus.cycle_cnt), 32'h0);

    // Program the table while idle
    lut_write(3, 'h25);
    lut_write(1, 7);
    lut_write(5, 'h3FE);

    // Sequential fetch
    pulse_start();
    check("start_pc",  32'(bus.pc),      32'h0);
    check("start_run", 32'(bus.running), 32'h1);
    repeat (5) tick();
    check("seq_pc",  32'(bus.pc),        32'h5);
    check("seq_cnt", 32'(bus.cycle_cnt), 32'h5);

    // Taken branch, not-taken branch, jump without branch
    take_branch(3);
    check("br_taken", 32'(bus.pc), 32'h25);
    bus.branch = 1'b1; bus.jump = 1'b0; bus.lut_idx = 4'd3;
    tick();
    check("br_not_taken", 32'(bus.pc), 32'h26);
    bus.branch = 1'b0; bus.jump = 1'b1;
    tick();
    check("jump_no_branch", 32'(bus.pc), 32'h27);
    bus.jump = 1'b0;

    // Stall dominates halt/branch, then halt
    take_branch(1);
    check("to_seven", 32'(bus.pc), 32'h7);
    snap_cnt = int'(bus.cycle_cnt);
    bus.stall = 1'b1; bus.halt = 1'b1; bus.branch = 1'b1; bus.jump = 1'b1; bus.lut_idx = 4'd3;
    repeat (3) tick();
    check("stall_pc",  32'(bus.pc),        32'h7);
    check("stall_cnt", 32'(bus.cycle_cnt), 32'(snap_cnt + 3));
    bus.stall = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
    tick();
    bus.halt = 1'b0;
    check("halt_ack",  32'(bus.ack),     32'h1);
    check("halt_pc",   32'(bus.pc),      32'h7);
    check("halt_run",  32'(bus.running), 32'h0);
    check("halt_cnt",  32'(bus.cycle_cnt), 32'(snap_cnt + 4));

    // Done holds, then restart
    snap_cnt = int'(bus.cycle_cnt);
    repeat (10) tick();
    check("done_ack", 32'(bus.ack),       32'h1);
    check("done_cnt", 32'(bus.cycle_cnt), 32'(snap_cnt));
    pulse_start();
    check("restart_pc",  32'(bus.pc),        32'h0);
    check("restart_ack", 32'(bus.ack),       32'h0);
    check("restart_cnt", 32'(bus.cycle_cnt), 32'h0);

    // PC wrap and counter saturation on the narrow instance
    take_branch(5);
    tick();
    check("pc_max", 32'(bus.pc), 32'h3FF);
    tick();
    check("pc_wrap", 32'(bus.pc), 32'h0);
    repeat (20) tick();
    check("sat_cnt_s", 32'(bus_s.cycle_cnt), 32'hF);

    // Start while running is ignored
    snap_cnt = int'(bus.pc);
    pulse_start();
    check("start_in_run", 32'(bus.pc), 32'(snap_cnt + 1));

    // Mid-run reset clears everything including the table
    lut_write(2, 'h12);
    take_branch(2);
    check("at_12", 32'(bus.pc), 32'h12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_pc",  32'(bus.pc),      32'h0);
    check("mid_rst_run", 32'(bus.running), 32'h0);
    check("mid_rst_ack", 32'(bus.ack),     32'h0);
    pulse_start();
    take_branch(3);
    check("lut_cleared", 32'(bus.pc), 32'h0);

    // Same-cycle write and branch uses old entry
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd4; bus.lut_wdata = 10'h55;
    take_branch(4);
    bus.lut_we = 1'b0;
    check("wr_br_old", 32'(bus.pc), 32'h0);
    take_branch(4);
    check("wr_br_new", 32'(bus.pc), 32'h55);

    // Reset overrides a table write
    reset = 1'b1; bus.lut_we = 1'b1; bus.lut_waddr = 4'd6; bus.lut_wdata = 10'h66;
    tick();
    reset = 1'b0; bus.lut_we = 1'b0;
    pulse_start();
    take_branch(6);
    check("rst_over_we", 32'(bus.pc), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.halt      = ($urandom_range(0, 15) == 0);
      bus.branch    = ($urandom_range(0, 2) == 0);
      bus.jump      = 1'($urandom_range(0, 1));
      bus.lut_idx   = LUTW'($urandom_range(0, 15));
      bus.lut_we    = ($urandom_range(0, 4) == 0);
      bus.lut_waddr = LUTW'($urandom_range(0, 15));
      bus.lut_wdata = PCW'($urandom_range(0, 1023));
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
